// File: rtl/warp_pkg.sv
// warp_pkg: shared constants and pick-result type for the warp fetch picker
package warp_pkg;
  localparam logic [1:0] RVC_NOT = 2'b11;
  localparam logic [3:0] INST_BYTES_32 = 4'd4;
  localparam logic [3:0] INST_BYTES_16 = 4'd2;
  typedef struct packed {
    logic [1:0]  compressed;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [3:0]  bytes;
  } pick_t;
endpackage

// File: rtl/warp_rvc_detect.sv
// warp_rvc_detect: flags a 16-bit halfword as the start of a compressed (RVC) instruction
module warp_rvc_detect
  import warp_pkg::*;
(
  input  logic [15:0] i_half,
  output logic        o_compressed
);
  // Only the two low bits select length; 48-bit+ encodings fall into the 32-bit class.
  logic w_unused;
  assign w_unused     = &{1'b0, i_half[15:2]};
  assign o_compressed = i_half[1:0] != RVC_NOT;
endmodule

// File: rtl/warp_pick_unit.sv
// warp_pick_unit: splits a 64-bit fetch word into two instruction slots with RVC flags.
// Optional output register stage enabled by defining WARP_PICK_REG_EN.
module warp_pick_unit
  import warp_pkg::*;
#(
  parameter int ZERO_UPPER = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_buffer,
  output logic        o_valid,
  output logic [1:0]  o_compressed,
  output logic [31:0] o_inst0,
  output logic [31:0] o_inst1,
  output logic [3:0]  o_bytes
);
  logic        w_c0;
  logic        w_c1;
  logic [31:0] w_inst1_raw;
  pick_t       w_pick;

  warp_rvc_detect u_det0 (.i_half(i_buffer[15:0]), .o_compressed(w_c0));

  // Slot 1 starts right after slot 0: halfword 1 if slot 0 is compressed, else halfword 2.
  assign w_inst1_raw = w_c0 ? i_buffer[47:16] : i_buffer[63:32];

  warp_rvc_detect u_det1 (.i_half(w_inst1_raw[15:0]), .o_compressed(w_c1));

  // Build the pick result, optionally blanking the unused upper half of compressed slots.
  always_comb begin
    w_pick.compressed = {w_c1, w_c0};
    w_pick.inst0      = {(ZERO_UPPER != 0 && w_c0) ? 16'h0 : i_buffer[31:16], i_buffer[15:0]};
    w_pick.inst1      = {(ZERO_UPPER != 0 && w_c1) ? 16'h0 : w_inst1_raw[31:16], w_inst1_raw[15:0]};
    w_pick.bytes      = (w_c0 ? INST_BYTES_16 : INST_BYTES_32) + (w_c1 ? INST_BYTES_16 : INST_BYTES_32);
  end

`ifdef WARP_PICK_REG_EN
  logic  r_valid;
  pick_t r_pick;

  // Output stage: valid every cycle, data captured only on valid words so it holds when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pick  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_pick <= w_pick;
    end
  end

  assign o_valid      = r_valid;
  assign o_compressed = r_pick.compressed;
  assign o_inst0      = r_pick.inst0;
  assign o_inst1      = r_pick.inst1;
  assign o_bytes      = r_pick.bytes;
`else
  logic w_unused_clk;
  assign w_unused_clk = i_clk;
  assign o_valid      = i_valid & i_rst_n;
  assign o_compressed = w_pick.compressed;
  assign o_inst0      = w_pick.inst0;
  assign o_inst1      = w_pick.inst1;
  assign o_bytes      = w_pick.bytes;
`endif
endmodule

// File: tb/tb_warp_pick_unit.sv
// tb_warp_pick_unit: scoreboard bench for warp_pick_unit, both ZERO_UPPER settings side by side
module tb_warp_pick_unit;
  typedef struct {
    logic [1:0]  comp;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i0z;
    logic [31:0] i1z;
    logic [3:0]  bytes;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_buffer = '0;
  logic        a_valid, b_valid;
  logic [1:0]  a_comp, b_comp;
  logic [31:0] a_i0, a_i1, b_i0, b_i1;
  logic [3:0]  a_bytes, b_bytes;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  warp_pick_unit #(.ZERO_UPPER(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_buffer(i_buffer),
    .o_valid(a_valid), .o_compressed(a_comp), .o_inst0(a_i0), .o_inst1(a_i1), .o_bytes(a_bytes)
  );
  warp_pick_unit #(.ZERO_UPPER(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_buffer(i_buffer),
    .o_valid(b_valid), .o_compressed(b_comp), .o_inst0(b_i0), .o_inst1(b_i1), .o_bytes(b_bytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [63:0] buf_v, input logic v, input exp_t e);
    @(posedge clk);
    #1;
    i_valid  = v;
    i_buffer = buf_v;
    if (v) q.push_back(e);
  endtask

  // Monitor: every presented output pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (a_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("compressed", {62'd0, a_comp}, {62'd0, e.comp});
        chk("inst0", {32'd0, a_i0}, {32'd0, e.i0});
        chk("inst1", {32'd0, a_i1}, {32'd0, e.i1});
        chk("bytes", {60'd0, a_bytes}, {60'd0, e.bytes});
        chk("zu_valid", {63'd0, b_valid}, 64'd1);
        chk("zu_compressed", {62'd0, b_comp}, {62'd0, e.comp});
        chk("zu_inst0", {32'd0, b_i0}, {32'd0, e.i0z});
        chk("zu_inst1", {32'd0, b_i1}, {32'd0, e.i1z});
        chk("zu_bytes", {60'd0, b_bytes}, {60'd0, e.bytes});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t c1, c2, c3, c4, c5, c6, none;
    logic [63:0] b1, b2, b3, b4, b5, b6;
    b1 = 64'h00000013_00000013; c1 = '{2'b00, 32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013, 4'd8};
    b2 = 64'h00000000_00010001; c2 = '{2'b11, 32'h00010001, 32'h00000001, 32'h00000001, 32'h00000001, 4'd4};
    b3 = 64'hFFFF0000_00130001; c3 = '{2'b01, 32'h00130001, 32'h00000013, 32'h00000001, 32'h00000013, 4'd6};
    b4 = 64'hABCD4501_00000013; c4 = '{2'b10, 32'h00000013, 32'hABCD4501, 32'h00000013, 32'h00004501, 4'd6};
    b5 = 64'h00000000_FFFFFFFF; c5 = '{2'b10, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'd6};
    b6 = 64'h12345678_0000001F; c6 = '{2'b10, 32'h0000001F, 32'h12345678, 32'h0000001F, 32'h00005678, 4'd6};
    none = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0};

    // Reset state
    i_buffer = b1;
    #12;
    chk("reset_valid", {63'd0, a_valid}, 64'd0);
`ifdef WARP_PICK_REG_EN
    chk("reset_inst0", {32'd0, a_i0}, 64'd0);
    chk("reset_bytes", {60'd0, a_bytes}, 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back valid words
    drive(b1, 1'b1, c1);
    drive(b2, 1'b1, c2);
    drive(b3, 1'b1, c3);
    drive(b4, 1'b1, c4);
    drive(b5, 1'b1, c5);
    drive(b6, 1'b1, c6);
    drive(b3, 1'b0, none);
    repeat (2) @(posedge clk);

    // Single pulse, then idle with a changed buffer
    drive(b1, 1'b1, c1);
    drive(b3, 1'b0, none);
    @(posedge clk);
    #1;
    chk("idle_valid", {63'd0, a_valid}, 64'd0);
`ifdef WARP_PICK_REG_EN
    chk("hold_inst0", {32'd0, a_i0}, {32'd0, c1.i0});
    chk("hold_bytes", {60'd0, a_bytes}, {60'd0, c1.bytes});
`else
    chk("follow_inst0", {32'd0, a_i0}, {32'd0, c3.i0});
    chk("follow_bytes", {60'd0, a_bytes}, {60'd0, c3.bytes});
`endif

    // Async reset while output valid
    drive(b2, 1'b1, c2);
    drive(b3, 1'b0, none);
    @(negedge clk);
    #1;
`ifdef WARP_PICK_REG_EN
    chk("pre_reset_valid", {63'd0, a_valid}, 64'd1);
`endif
    i_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("async_reset_valid", {63'd0, a_valid}, 64'd0);
`ifdef WARP_PICK_REG_EN
    chk("async_reset_comp", {62'd0, a_comp}, 64'd0);
    chk("async_reset_inst0", {32'd0, a_i0}, 64'd0);
    chk("async_reset_inst1", {32'd0, a_i1}, 64'd0);
    chk("async_reset_bytes", {60'd0, a_bytes}, 64'd0);
`endif
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency after reset release
    drive(b4, 1'b1, c4);
    @(negedge clk);
    #1;
`ifdef WARP_PICK_REG_EN
    chk("latency_same_cycle", {63'd0, a_valid}, 64'd0);
`else
    chk("latency_same_cycle", {63'd0, a_valid}, 64'd1);
`endif
    drive(b1, 1'b0, none);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
